// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_wb_arbiter_pkg: shared widths, queue geometry and the queued write-back entry type.
package regfile_wb_arbiter_pkg;
   localparam int DEPTH = 4;
   localparam int DATA_W = 32;
   localparam int IDX_W = 5;
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [IDX_W-1:0] ZERO_REG = '0;
   typedef struct packed {
      logic              valid;
      logic [IDX_W-1:0]  idx;
      logic [DATA_W-1:0] data;
   } wb_entry_t;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: ALU/latency result inputs, regfile write port, and operand read/forward signals.
interface regfile_wb_arbiter_if;
   import regfile_wb_arbiter_pkg::*;
   logic              alu_valid;
   logic [IDX_W-1:0]  alu_idx;
   logic [DATA_W-1:0] alu_data;
   logic              lat_valid;
   logic              lat_ready;
   logic [IDX_W-1:0]  lat_idx;
   logic [DATA_W-1:0] lat_data;
   logic              wr_en;
   logic [IDX_W-1:0]  wr_idx;
   logic [DATA_W-1:0] wr_data;
   logic [IDX_W-1:0]  rda_idx;
   logic [IDX_W-1:0]  rdb_idx;
   logic [DATA_W-1:0] rf_rda;
   logic [DATA_W-1:0] rf_rdb;
   logic [DATA_W-1:0] rda_val;
   logic [DATA_W-1:0] rdb_val;
   logic              stall_a;
   logic              stall_b;
   logic [CNT_W-1:0]  q_count;
   modport slave (
      input  alu_valid, alu_idx, alu_data, lat_valid, lat_idx, lat_data,
             rda_idx, rdb_idx, rf_rda, rf_rdb,
      output lat_ready, wr_en, wr_idx, wr_data, rda_val, rdb_val, stall_a, stall_b, q_count
   );
   modport master (
      output alu_valid, alu_idx, alu_data, lat_valid, lat_idx, lat_data,
             rda_idx, rdb_idx, rf_rda, rf_rdb,
      input  lat_ready, wr_en, wr_idx, wr_data, rda_val, rdb_val, stall_a, stall_b, q_count
   );
endinterface

// File: rtl/regfile_wb_arbiter_wb_queue.sv
// wb_queue: circular FIFO of pending latency results with index-based kill and per-entry read-index match.
module wb_queue
   import regfile_wb_arbiter_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  wb_entry_t        push_entry,
   input  logic             pop,
   input  logic             kill_en,
   input  logic [IDX_W-1:0] kill_idx,
   input  logic [IDX_W-1:0] idx_a,
   input  logic [IDX_W-1:0] idx_b,
   output wb_entry_t        head,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty,
   output logic [DEPTH-1:0] match_a,
   output logic [DEPTH-1:0] match_b
);
   wb_entry_t        mem_q [DEPTH];
   wb_entry_t        mem_d [DEPTH];
   logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;

   // Popped slots drop their valid bit so the match vectors only ever see live entries.
   always_comb begin
      mem_d = mem_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (kill_en && mem_q[i].idx == kill_idx) mem_d[i].valid = 1'b0;
         match_a[i] = mem_q[i].valid && mem_q[i].idx == idx_a;
         match_b[i] = mem_q[i].valid && mem_q[i].idx == idx_b;
      end
      if (pop) mem_d[head_q].valid = 1'b0;
      if (push) mem_d[tail_q] = push_entry;
      head_d = head_q + PTR_W'(pop);
      tail_d = tail_q + PTR_W'(push);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         head_q <= '0;
         tail_q <= '0;
         count_q <= '0;
      end else begin
         mem_q <= mem_d;
         head_q <= head_d;
         tail_q <= tail_d;
         count_q <= count_d;
      end
   end

   assign head = mem_q[head_q];
   assign count = count_q;
   assign full = count_q == CNT_W'(DEPTH);
   assign empty = count_q == '0;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: merges ALU and long-latency results onto one regfile write port,
// keeping WAW order, forwarding the in-flight write and flagging reads of queued writes.
module regfile_wb_arbiter
   import regfile_wb_arbiter_pkg::*;
(
   input logic                 clk,
   input logic                 rst_n,
   regfile_wb_arbiter_if.slave bus
);
   logic              alu_ok, lat_ok, pop, bypass, push, ld;
   logic              full, empty;
   logic [CNT_W-1:0]  count;
   logic [DEPTH-1:0]  match_a, match_b;
   wb_entry_t         head, push_entry;
   logic              wr_en_q, wr_en_d;
   logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;

   // A latency result landing with the same index as this cycle's ALU write is older, so it is dropped.
   always_comb begin
      alu_ok = bus.alu_valid && bus.alu_idx != ZERO_REG;
      lat_ok = bus.lat_valid && !full && bus.lat_idx != ZERO_REG && !(alu_ok && bus.lat_idx == bus.alu_idx);
      pop = !alu_ok && !empty;
      bypass = !alu_ok && empty && lat_ok;
      push = lat_ok && !bypass;
      push_entry = '{valid: 1'b1, idx: bus.lat_idx, data: bus.lat_data};
      ld = alu_ok || (pop && head.valid) || bypass;
      wr_en_d = ld;
      wr_idx_d = alu_ok ? bus.alu_idx : (pop && head.valid) ? head.idx : bypass ? bus.lat_idx : wr_idx_q;
      wr_data_d = alu_ok ? bus.alu_data : (pop && head.valid) ? head.data : bypass ? bus.lat_data : wr_data_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_en_q <= 1'b0;
         wr_idx_q <= '0;
         wr_data_q <= '0;
      end else begin
         wr_en_q <= wr_en_d;
         wr_idx_q <= wr_idx_d;
         wr_data_q <= wr_data_d;
      end
   end

   wb_queue u_queue (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .kill_en    (alu_ok),
      .kill_idx   (bus.alu_idx),
      .idx_a      (bus.rda_idx),
      .idx_b      (bus.rdb_idx),
      .head       (head),
      .count      (count),
      .full       (full),
      .empty      (empty),
      .match_a    (match_a),
      .match_b    (match_b)
   );

   assign bus.lat_ready = !full;
   assign bus.wr_en = wr_en_q;
   assign bus.wr_idx = wr_idx_q;
   assign bus.wr_data = wr_data_q;
   assign bus.q_count = count;
   assign bus.rda_val = (wr_en_q && wr_idx_q == bus.rda_idx && bus.rda_idx != ZERO_REG) ? wr_data_q : bus.rf_rda;
   assign bus.rdb_val = (wr_en_q && wr_idx_q == bus.rdb_idx && bus.rdb_idx != ZERO_REG) ? wr_data_q : bus.rf_rdb;
   assign bus.stall_a = bus.rda_idx != ZERO_REG && |match_a;
   assign bus.stall_b = bus.rdb_idx != ZERO_REG && |match_b;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed per-cycle vector table plus reset and reset-mid-stream sequences.
module tb_regfile_wb_arbiter;
   localparam logic [31:0] RA = 32'hAAAA_0000;
   localparam logic [31:0] RB = 32'hBBBB_0000;

   typedef struct {
      logic        av;
      logic [4:0]  ai;
      logic [31:0] ad;
      logic        lv;
      logic [4:0]  li;
      logic [31:0] ld;
      logic [4:0]  ra;
      logic [4:0]  rb;
      logic        e_en;
      logic [4:0]  e_idx;
      logic [31:0] e_data;
      logic [2:0]  e_cnt;
      logic        e_rdy;
      logic        e_sa;
      logic        e_sb;
      logic [31:0] e_rav;
      logic [31:0] e_rbv;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_pass = 0;
   int   n_total = 0;
   vec_t vt [23];

   regfile_wb_arbiter_if bus ();
   regfile_wb_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   function automatic vec_t v(input logic av, input logic [4:0] ai, input logic [31:0] ad,
                              input logic lv, input logic [4:0] li, input logic [31:0] ld,
                              input logic [4:0] ra, input logic [4:0] rb,
                              input logic e_en, input logic [4:0] e_idx, input logic [31:0] e_data,
                              input logic [2:0] e_cnt, input logic e_rdy, input logic e_sa, input logic e_sb,
                              input logic [31:0] e_rav, input logic [31:0] e_rbv);
      v = '{av, ai, ad, lv, li, ld, ra, rb, e_en, e_idx, e_data, e_cnt, e_rdy, e_sa, e_sb, e_rav, e_rbv};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
   endtask

   task automatic drive(input logic av, input logic [4:0] ai, input logic [31:0] ad,
                        input logic lv, input logic [4:0] li, input logic [31:0] ld,
                        input logic [4:0] ra, input logic [4:0] rb);
      bus.alu_valid = av; bus.alu_idx = ai; bus.alu_data = ad;
      bus.lat_valid = lv; bus.lat_idx = li; bus.lat_data = ld;
      bus.rda_idx = ra; bus.rdb_idx = rb;
   endtask

   initial begin
      bus.rf_rda = RA;
      bus.rf_rdb = RB;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      vt[0]  = v(0, 0, 0,       1, 5, 'hAA,   5, 0, 1, 5, 'hAA,   0, 1, 0, 0, 'hAA, RB);
      vt[1]  = v(0, 0, 0,       0, 0, 0,     5, 5, 0, 5, 'hAA,   0, 1, 0, 0, RA, RB);
      vt[2]  = v(1, 1, 'h101,   1, 7, 'h207,  1, 9, 1, 1, 'h101,  1, 1, 0, 0, 'h101, RB);
      vt[3]  = v(1, 2, 'h102,   1, 8, 'h208,  1, 9, 1, 2, 'h102,  2, 1, 0, 0, RA, RB);
      vt[4]  = v(1, 3, 'h103,   1, 9, 'h209,  1, 9, 1, 3, 'h103,  3, 1, 0, 1, RA, RB);
      vt[5]  = v(1, 4, 'h104,   1, 10, 'h20A, 1, 9, 1, 4, 'h104,  4, 0, 0, 1, RA, RB);
      vt[6]  = v(1, 5, 'h105,   1, 11, 'h20B, 1, 9, 1, 5, 'h105,  4, 0, 0, 1, RA, RB);
      vt[7]  = v(1, 6, 'h106,   1, 11, 'h20B, 1, 9, 1, 6, 'h106,  4, 0, 0, 1, RA, RB);
      vt[8]  = v(0, 0, 0,       1, 11, 'h20B, 1, 9, 1, 7, 'h207,  3, 1, 0, 1, RA, RB);
      vt[9]  = v(0, 0, 0,       1, 11, 'h20B, 1, 9, 1, 8, 'h208,  3, 1, 0, 1, RA, RB);
      vt[10] = v(0, 0, 0,       0, 0, 0,     1, 9, 1, 9, 'h209,  2, 1, 0, 0, RA, 'h209);
      vt[11] = v(0, 0, 0,       0, 0, 0,     1, 9, 1, 10, 'h20A, 1, 1, 0, 0, RA, RB);
      vt[12] = v(0, 0, 0,       0, 0, 0,     1, 9, 1, 11, 'h20B, 0, 1, 0, 0, RA, RB);
      vt[13] = v(0, 0, 0,       0, 0, 0,     1, 9, 0, 11, 'h20B, 0, 1, 0, 0, RA, RB);
      vt[14] = v(1, 1, 'h31,    1, 3, 'h11,   3, 0, 1, 1, 'h31,   1, 1, 1, 0, RA, RB);
      vt[15] = v(1, 3, 'h22,    0, 0, 0,     3, 0, 1, 3, 'h22,   1, 1, 0, 0, 'h22, RB);
      vt[16] = v(0, 0, 0,       0, 0, 0,     3, 0, 0, 3, 'h22,   0, 1, 0, 0, RA, RB);
      vt[17] = v(1, 6, 'h66,    1, 6, 'h77,   6, 0, 1, 6, 'h66,   0, 1, 0, 0, 'h66, RB);
      vt[18] = v(0, 0, 0,       0, 0, 0,     6, 0, 0, 6, 'h66,   0, 1, 0, 0, RA, RB);
      vt[19] = v(1, 0, 'h99,    1, 0, 'h98,   0, 0, 0, 6, 'h66,   0, 1, 0, 0, RA, RB);
      vt[20] = v(1, 0, 'h99,    1, 12, 'hC,   0, 12, 1, 12, 'hC,  0, 1, 0, 0, RA, 'hC);
      vt[21] = v(0, 0, 0,       1, 0, 'h98,   0, 12, 0, 12, 'hC,  0, 1, 0, 0, RA, RB);
      vt[22] = v(1, 4, 'h5,     0, 0, 0,     4, 4, 1, 4, 'h5,    0, 1, 0, 0, 'h5, 'h5);

      #2;
      chk("reset wr_en", 32'(bus.wr_en), 0);
      chk("reset wr_idx", 32'(bus.wr_idx), 0);
      chk("reset wr_data", bus.wr_data, 0);
      chk("reset q_count", 32'(bus.q_count), 0);
      chk("reset lat_ready", 32'(bus.lat_ready), 1);
      chk("reset stall_a", 32'(bus.stall_a), 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 23; i++) begin
         drive(vt[i].av, vt[i].ai, vt[i].ad, vt[i].lv, vt[i].li, vt[i].ld, vt[i].ra, vt[i].rb);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d wr_en", i), 32'(bus.wr_en), 32'(vt[i].e_en));
         chk($sformatf("v%0d wr_idx", i), 32'(bus.wr_idx), 32'(vt[i].e_idx));
         chk($sformatf("v%0d wr_data", i), bus.wr_data, vt[i].e_data);
         chk($sformatf("v%0d q_count", i), 32'(bus.q_count), 32'(vt[i].e_cnt));
         chk($sformatf("v%0d lat_ready", i), 32'(bus.lat_ready), 32'(vt[i].e_rdy));
         chk($sformatf("v%0d stall_a", i), 32'(bus.stall_a), 32'(vt[i].e_sa));
         chk($sformatf("v%0d stall_b", i), 32'(bus.stall_b), 32'(vt[i].e_sb));
         chk($sformatf("v%0d rda_val", i), bus.rda_val, vt[i].e_rav);
         chk($sformatf("v%0d rdb_val", i), bus.rdb_val, vt[i].e_rbv);
      end

      for (int i = 0; i < 3; i++) begin
         drive(1, 5'(i + 1), 32'(i), 1, 5'(i + 13), 32'(i + 'h300), 14, 0);
         @(posedge clk);
         #1;
      end
      drive(0, 0, 0, 0, 0, 0, 14, 0);
      chk("pre-rst q_count", 32'(bus.q_count), 3);
      chk("pre-rst stall_a", 32'(bus.stall_a), 1);
      chk("pre-rst wr_idx", 32'(bus.wr_idx), 3);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid-rst wr_en", 32'(bus.wr_en), 0);
      chk("mid-rst q_count", 32'(bus.q_count), 0);
      chk("mid-rst lat_ready", 32'(bus.lat_ready), 1);
      chk("mid-rst stall_a", 32'(bus.stall_a), 0);
      chk("mid-rst wr_idx", 32'(bus.wr_idx), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) begin
         @(posedge clk);
         #1;
         chk("post-rst wr_en", 32'(bus.wr_en), 0);
         chk("post-rst q_count", 32'(bus.q_count), 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
